// File: rtl/fir_pkg.sv
// Shared types and width helpers for the time-multiplexed FIR scheduler.
package fir_pkg;

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_WAIT,
      ST_MAC,
      ST_OUT
   } fir_state_t;

   localparam int N_TAPS_DEF     = 2;
   localparam int BW_IN_DEF      = 6;
   localparam int BW_PRODUCT_DEF = 12;
   localparam int BW_OUT_DEF     = 8;

   // Accumulator wide enough that summing N_TAPS full-scale products cannot overflow.
   localparam int ACC_W     = BW_PRODUCT_DEF + $clog2(N_TAPS_DEF);
   localparam int TAP_IDX_W = $clog2(N_TAPS_DEF);

   function automatic int acc_width(input int n_taps, input int bw_product);
      return bw_product + $clog2(n_taps);
   endfunction

   // A tap/word index needs at least one bit even for the smallest filter.
   function automatic int idx_width(input int n_taps);
      return ($clog2(n_taps) < 1) ? 1 : $clog2(n_taps);
   endfunction

endpackage

// File: rtl/fir_mac.sv
// Shared signed multiplier plus accumulator; one product is folded in per enabled cycle.
// acc_nxt exposes the sum that the next enabled edge will store, so the scheduler
// can register the final result on the last tap without an extra cycle.
module fir_mac
   import fir_pkg::*;
#(
   parameter int BW_IN      = BW_IN_DEF,
   parameter int BW_PRODUCT = BW_PRODUCT_DEF,
   parameter int ACC_BITS   = ACC_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clr,
   input  logic                       en,
   input  logic signed [BW_IN-1:0]    a,
   input  logic signed [BW_IN-1:0]    b,
   output logic signed [ACC_BITS-1:0] acc_nxt
);

   logic signed [ACC_BITS-1:0]   acc;
   logic signed [BW_PRODUCT-1:0] prod;

   assign prod    = BW_PRODUCT'(a) * BW_PRODUCT'(b);
   assign acc_nxt = acc + ACC_BITS'(prod);

   // Accumulator register: clear has priority over accumulate.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc_nxt;
      end
   end

endmodule

// File: rtl/fir_mac_sched.sv
// Scheduler for a time-multiplexed FIR: coefficient load, sample delay line,
// one tap per cycle through a single fir_mac, valid/ready on both sides.
// Optional build macro: FIR_SATURATE_EN (clamp output instead of truncating).
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_LOAD | accepting coefficient words into coef[0..N_TAPS-1]
// ST_WAIT | idle, accepting the next sample (or a reload request)
// ST_MAC  | stepping the shared multiplier across all taps
// ST_OUT  | result presented, held until out_ready
module fir_mac_sched
   import fir_pkg::*;
#(
   parameter int N_TAPS     = N_TAPS_DEF,
   parameter int BW_IN      = BW_IN_DEF,
   parameter int BW_PRODUCT = BW_PRODUCT_DEF,
   parameter int BW_OUT     = BW_OUT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_load,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [BW_IN-1:0]  in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BW_OUT-1:0] out_data,
   output logic              loading
);

   localparam int ACC_BITS = acc_width(N_TAPS, BW_PRODUCT);
   localparam int IDX_BITS = idx_width(N_TAPS);
   localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(N_TAPS - 1);

   fir_state_t                 state;
   logic [IDX_BITS-1:0]        load_cnt;
   logic [IDX_BITS-1:0]        tap_cnt;
   logic signed [BW_IN-1:0]    coef [N_TAPS];
   logic signed [BW_IN-1:0]    x    [N_TAPS];
   logic signed [ACC_BITS-1:0] acc_nxt;
   logic [BW_OUT-1:0]          y_fmt;
   logic                       sample_take;
   logic                       mac_en;

   assign in_ready    = !reset && ((state == ST_LOAD) || (state == ST_WAIT && !cfg_load));
   assign loading     = (state == ST_LOAD);
   assign sample_take = (state == ST_WAIT) && !cfg_load && in_valid;
   assign mac_en      = (state == ST_MAC);

   fir_mac #(
      .BW_IN      (BW_IN),
      .BW_PRODUCT (BW_PRODUCT),
      .ACC_BITS   (ACC_BITS)
   ) u_mac (
      .clk     (clk),
      .reset   (reset),
      .clr     (sample_take),
      .en      (mac_en),
      .a       (x[tap_cnt]),
      .b       (coef[tap_cnt]),
      .acc_nxt (acc_nxt)
   );

`ifdef FIR_SATURATE_EN
   localparam logic signed [ACC_BITS-1:0] SAT_HI =
      {{(ACC_BITS-BW_OUT+1){1'b0}}, {(BW_OUT-1){1'b1}}};
   localparam logic signed [ACC_BITS-1:0] SAT_LO =
      {{(ACC_BITS-BW_OUT+1){1'b1}}, {(BW_OUT-1){1'b0}}};
`endif

   // Map the final accumulator value onto the output width.
   always_comb begin
`ifdef FIR_SATURATE_EN
      if (acc_nxt > SAT_HI) begin
         y_fmt = SAT_HI[BW_OUT-1:0];
      end else if (acc_nxt < SAT_LO) begin
         y_fmt = SAT_LO[BW_OUT-1:0];
      end else begin
         y_fmt = acc_nxt[BW_OUT-1:0];
      end
`else
      y_fmt = BW_OUT'(acc_nxt);
`endif
   end

   // Sequencing FSM with its counters, coefficient/delay-line storage and output register.
   // The MAC walks taps with a down-counter; summation order does not affect the result.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_LOAD;
         load_cnt  <= '0;
         tap_cnt   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         for (int k = 0; k < N_TAPS; k++) begin
            coef[k] <= '0;
            x[k]    <= '0;
         end
      end else begin
         unique case (state)
            ST_LOAD: begin
               if (cfg_load) begin
                  load_cnt <= '0;
               end else if (in_valid) begin
                  coef[load_cnt] <= in_data;
                  if (load_cnt == LAST_IDX) begin
                     load_cnt <= '0;
                     state    <= ST_WAIT;
                  end else begin
                     load_cnt <= load_cnt + 1'b1;
                  end
               end
            end
            ST_WAIT: begin
               if (cfg_load) begin
                  load_cnt <= '0;
                  state    <= ST_LOAD;
                  for (int k = 0; k < N_TAPS; k++) begin
                     x[k] <= '0;
                  end
               end else if (in_valid) begin
                  for (int k = N_TAPS - 1; k > 0; k--) begin
                     x[k] <= x[k-1];
                  end
                  x[0]    <= in_data;
                  tap_cnt <= LAST_IDX;
                  state   <= ST_MAC;
               end
            end
            ST_MAC: begin
               if (tap_cnt == '0) begin
                  out_valid <= 1'b1;
                  out_data  <= y_fmt;
                  state     <= ST_OUT;
               end else begin
                  tap_cnt <= tap_cnt - 1'b1;
               end
            end
            ST_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ST_WAIT;
               end
            end
            default: state <= ST_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_mac_sched.sv
// Directed bench for fir_mac_sched (N_TAPS=2, BW_IN=6, BW_OUT=8) with a
// transaction-level reference model checked every cycle.
module tb_fir_mac_sched;

   localparam int N = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       cfg_load;
   logic       in_valid;
   logic       in_ready;
   logic [5:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       loading;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc_n   = 0;
   bit chk_en  = 0;

   fir_mac_sched dut (
      .clk       (clk),
      .reset     (reset),
      .cfg_load  (cfg_load),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .loading   (loading)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic chk(input bit ok, input string nm, input int act, input int exp);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc_n);
      end
   endtask

   function automatic logic [7:0] fmt(input int v);
`ifdef FIR_SATURATE_EN
      if (v > 127) return 8'h7F;
      if (v < -128) return 8'h80;
`endif
      return v[7:0];
   endfunction

   // ---------------- reference model ----------------
   // mode: 0 loading coefficients, 1 idle, 2 computing, 3 result pending
   int         m_mode;
   int         m_k;
   int         m_busy;
   int         m_coef [N];
   int         m_x    [N];
   bit         m_valid;
   logic [7:0] m_data;
   logic [7:0] m_pend;

   always @(posedge clk) begin
      if (reset) begin
         m_mode = 0; m_k = 0; m_busy = 0; m_valid = 0; m_data = 8'h00; m_pend = 8'h00;
         for (int k = 0; k < N; k++) begin m_coef[k] = 0; m_x[k] = 0; end
      end else begin
         case (m_mode)
            0: if (cfg_load) m_k = 0;
               else if (in_valid) begin
                  m_coef[m_k] = $signed(in_data);
                  m_k++;
                  if (m_k == N) begin m_k = 0; m_mode = 1; end
               end
            1: if (cfg_load) begin
                  m_mode = 0; m_k = 0;
                  for (int k = 0; k < N; k++) m_x[k] = 0;
               end else if (in_valid) begin
                  int s;
                  for (int k = N - 1; k > 0; k--) m_x[k] = m_x[k-1];
                  m_x[0] = $signed(in_data);
                  s = 0;
                  for (int k = 0; k < N; k++) s += m_x[k] * m_coef[k];
                  m_pend = fmt(s);
                  m_busy = N;
                  m_mode = 2;
               end
            2: begin
               m_busy--;
               if (m_busy == 0) begin m_mode = 3; m_valid = 1; m_data = m_pend; end
            end
            default: if (out_ready) begin m_valid = 0; m_mode = 1; end
         endcase
      end
   end

   // Per-cycle comparison of DUT outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         bit exp_rdy;
         exp_rdy = !reset && (m_mode == 0 || (m_mode == 1 && !cfg_load));
         chk(in_ready === exp_rdy, "model in_ready", int'(in_ready), int'(exp_rdy));
         chk(loading === (m_mode == 0), "model loading", int'(loading), int'(m_mode == 0));
         chk(out_valid === m_valid, "model out_valid", int'(out_valid), int'(m_valid));
         chk(out_data === m_data, "model out_data", int'(out_data), int'(m_data));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_word(input int d, output int t_acc);
      bit done = 0;
      int n = 0;
      in_valid = 1'b1;
      in_data  = 6'(d);
      t_acc    = -1;
      while (!done && n < 40) begin
         @(negedge clk);
         if (in_ready) begin done = 1; t_acc = cyc_n; end
         else n++;
      end
      if (!done) chk(0, "handshake timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic pulse_cfg();
      cfg_load = 1'b1;
      @(posedge clk); #1;
      cfg_load = 1'b0;
   endtask

   task automatic wait_out(input logic [7:0] exp, input string nm, input int t_acc, input int hold);
      bit seen = 0;
      int n = 0;
      logic [7:0] held;
      while (!seen && n < 40) begin
         @(negedge clk);
         if (out_valid) seen = 1; else n++;
      end
      if (!seen) begin
         chk(0, {nm, " out_valid timeout"}, 0, 1);
      end else begin
         chk(out_data === exp, nm, int'(out_data), int'(exp));
         if (t_acc >= 0) chk(cyc_n == t_acc + N + 1, {nm, " latency"}, cyc_n - t_acc, N + 1);
         held = out_data;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            chk(out_valid === 1'b1, "hold out_valid", int'(out_valid), 1);
            chk(out_data === held, "hold out_data", int'(out_data), int'(held));
            chk(in_ready === 1'b0, "hold in_ready", int'(in_ready), 0);
         end
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic load2(input int c0, input int c1);
      int t;
      send_word(c0, t);
      send_word(c1, t);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int t;
      reset = 1'b1; cfg_load = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      chk_en = 1;
      @(negedge clk);
      chk(out_valid === 1'b0, "reset out_valid", int'(out_valid), 0);
      chk(out_data === 8'h00, "reset out_data", int'(out_data), 0);
      chk(in_ready === 1'b0, "reset-cycle in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk(loading === 1'b1, "post-reset loading", int'(loading), 1);
      chk(in_ready === 1'b1, "post-reset in_ready", int'(in_ready), 1);
      @(posedge clk); #1;

      // 1: coef 3,-2; samples 5 then 4
      load2(3, -2);
      send_word(5, t);
      wait_out(8'd15, "t1 y0", t, 0);
      send_word(4, t);
      wait_out(8'd2, "t1 y1", t, 0);

      // 2: full-scale products
      pulse_cfg();
      load2(31, 31);
      send_word(31, t);
      wait_out(fmt(961), "t2 y0", -1, 0);
      send_word(31, t);
`ifdef FIR_SATURATE_EN
      wait_out(8'h7F, "t2 y1 sat", t, 0);
`else
      wait_out(8'h82, "t2 y1 wrap", t, 0);
`endif

      // 3: output back-pressure with a sample already waiting
      pulse_cfg();
      load2(3, -2);
      send_word(5, t);
      in_valid = 1'b1;
      in_data  = 6'd4;
      wait_out(8'd15, "t3 y0", t, 5);
      send_word(4, t);
      wait_out(8'd2, "t3 y1", t, 0);

      // 4: reset while computing
      send_word(6, t);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk(out_valid === 1'b0, "t4 out_valid after reset", int'(out_valid), 0);
      chk(loading === 1'b1, "t4 loading after reset", int'(loading), 1);
      @(posedge clk); #1;
      load2(3, -2);
      send_word(2, t);
      wait_out(8'd6, "t4 y cleared line", t, 0);

      // 5: reload request ignored while computing, honoured when idle
      send_word(5, t);
      pulse_cfg();
      wait_out(8'd11, "t5 y kept", t, 0);
      @(negedge clk);
      chk(loading === 1'b0, "t5 no reload from MAC", int'(loading), 0);
      @(posedge clk); #1;
      pulse_cfg();
      load2(-2, 1);
      send_word(7, t);
      wait_out(8'hF2, "t5 y after reload", t, 0);

      // 6: restart of the word count mid-load
      pulse_cfg();
      send_word(9, t);
      pulse_cfg();
      load2(2, 3);
      @(negedge clk);
      chk(loading === 1'b0, "t6 load done", int'(loading), 0);
      @(posedge clk); #1;
      send_word(1, t);
      wait_out(8'd2, "t6 y0", t, 0);
      send_word(1, t);
      wait_out(8'd5, "t6 y1", t, 0);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
